// File: rtl/xor_share_ctrl.sv
// rtl/xor_share_ctrl.sv - round-robin scheduler sharing one external 1-bit XOR cell among N requesters
module xor_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(N_REQ),
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   xor_a,
  output logic                   xor_b,
  input  logic                   xor_y,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_data,
  output logic [IDW-1:0]         resp_id
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     id;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   r;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [N_REQ-1:0]   grant;
  logic [IDW-1:0]     gidx;
  logic               found;
  logic [2*N_REQ-1:0] rot_dbl;
  logic [WIDTH-1:0]   a_arr [N_REQ];
  logic [WIDTH-1:0]   b_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Rotate valids so bit 0 is the requester at ptr, then take the first set bit.
  assign rot_dbl = {req_valid, req_valid} >> ptr;

  always_comb begin
    int s;
    s     = 0;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot_dbl[k]) begin
        found = 1'b1;
        s = int'(ptr) + k;
        if (s >= N_REQ) s = s - N_REQ;
        gidx = IDW'(s);
      end
    end
    if (found && state == IDLE && rst_n) grant[gidx] = 1'b1;
  end

  assign req_ready  = grant;
  assign xor_a      = (state == SHIFT) ? sa[0] : 1'b0;
  assign xor_b      = (state == SHIFT) ? sb[0] : 1'b0;
  assign resp_valid = (state == DONE);
  assign resp_data  = (state == DONE) ? r : '0;
  assign resp_id    = (state == DONE) ? id : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      id    <= '0;
      cnt   <= '0;
      r     <= '0;
      sa    <= '0;
      sb    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|grant) begin
            sa  <= a_arr[gidx];
            sb  <= b_arr[gidx];
            id  <= gidx;
            cnt <= '0;
            r   <= '0;
          end
        end
        SHIFT: begin
          // Result fills from the top so the LSB-first stream lands in order.
          r   <= {xor_y, r[WIDTH-1:1]};
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          if (resp_ready) ptr <= (id == IDW'(N_REQ - 1)) ? '0 : id + IDW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_ctrl.sv
// tb/tb_xor_share_ctrl.sv - directed self-checking bench for xor_share_ctrl
module tb_xor_share_ctrl;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           xor_a, xor_b, xor_y;
  logic           resp_valid;
  logic           resp_ready = 1'b1;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;

  int total = 0;
  int bad = 0;

  xor_share_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .xor_a(xor_a), .xor_b(xor_b), .xor_y(xor_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
  );

  // Shared XOR cell instance
  assign xor_y = xor_a ^ xor_b;

  always #5 clk = ~clk;

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int g, output bit ok);
    ok = 1'b0;
    g = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int j = 0; j < N; j++) if (req_ready[j]) g = j;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (resp_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    total++;
    if ({resp_valid, resp_data, resp_id, xor_a, xor_b, req_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h id=%0d xa=%b xb=%b rdy=%b required all 0",
               resp_valid, resp_data, resp_id, xor_a, xor_b, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_single;
    logic [7:0] xa_seq = 8'b10100101;
    logic [7:0] xb_seq = 8'b00111100;
    do_reset;
    req_a[7:0] = 8'hA5;
    req_b[7:0] = 8'h3C;
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_grant got=%b required=0001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({resp_valid, xor_a, xor_b} !== {1'b0, xa_seq[k], xb_seq[k]}) begin
        bad++;
        $display("FAIL single_bit%0d got v/a/b=%b%b%b required=0%b%b",
                 k, resp_valid, xor_a, xor_b, xa_seq[k], xb_seq[k]);
      end
      @(negedge clk);
    end
    total++;
    if ({resp_valid, resp_data, resp_id} !== {1'b1, 8'h99, 2'd0}) begin
      bad++;
      $display("FAIL single_resp got v=%b d=%h id=%0d required v=1 d=99 id=0",
               resp_valid, resp_data, resp_id);
    end
    @(negedge clk);
    total++;
    if ({resp_valid, xor_a, xor_b} !== 3'b000) begin
      bad++;
      $display("FAIL single_after got v/a/b=%b%b%b required=000", resp_valid, xor_a, xor_b);
    end
  endtask

  task automatic test_extremes;
    logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h01};
    logic [7:0] vb [3] = '{8'hFF, 8'h00, 8'h80};
    logic [7:0] ve [3] = '{8'h00, 8'hFF, 8'h81};
    int g;
    bit ok;
    for (int t = 0; t < 3; t++) begin
      req_a[7:0] = va[t];
      req_b[7:0] = vb[t];
      req_valid = 4'b0001;
      wait_grant(g, ok);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      wait_resp(ok);
      total++;
      if (!ok || resp_data !== ve[t]) begin
        bad++;
        $display("FAIL extreme%0d got ok=%b d=%h required d=%h", t, ok, resp_data, ve[t]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d [4] = '{8'h1D, 8'hC4, 8'hFC, 8'h2D};
    int g;
    bit ok;
    do_reset;
    req_a = {8'h78, 8'h56, 8'h34, 8'h12};
    req_b = {8'h55, 8'hAA, 8'hF0, 8'h0F};
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, ok);
      total++;
      if (!ok || g != order[k] || !$onehot(req_ready)) begin
        bad++;
        $display("FAIL rr_grant%0d got ok=%b rdy=%b required grant %0d one-hot", k, ok, req_ready, order[k]);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL rr_busy%0d got rdy=%b required=0000", k, req_ready);
      end
      wait_resp(ok);
      total++;
      if (!ok || resp_data !== exp_d[order[k]] || resp_id !== 2'(order[k])) begin
        bad++;
        $display("FAIL rr_resp%0d got ok=%b d=%h id=%0d required d=%h id=%0d",
                 k, ok, resp_data, resp_id, exp_d[order[k]], order[k]);
      end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_ptr_wrap;
    int g;
    bit ok;
    do_reset;
    req_a = {8'h3A, 8'h00, 8'h00, 8'hC5};
    req_b = {8'h11, 8'h00, 8'h00, 8'h22};
    req_valid = 4'b1000;
    wait_grant(g, ok);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    total++;
    if (!ok || resp_id !== 2'd3 || resp_data !== 8'h2B) begin
      bad++;
      $display("FAIL wrap_first got ok=%b id=%0d d=%h required id=3 d=2b", ok, resp_id, resp_data);
    end
    req_valid = 4'b1001;
    wait_grant(g, ok);
    total++;
    if (!ok || g != 0) begin
      bad++;
      $display("FAIL wrap_grant got ok=%b g=%0d required 0", ok, g);
    end
    @(posedge clk);
    @(negedge clk);
    wait_resp(ok);
    @(negedge clk);
    wait_grant(g, ok);
    total++;
    if (!ok || g != 3) begin
      bad++;
      $display("FAIL wrap_next got ok=%b g=%0d required 3", ok, g);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int g;
    bit ok;
    do_reset;
    resp_ready = 1'b0;
    req_a[15:0] = {8'h0F, 8'hC3};
    req_b[15:0] = {8'h33, 8'h5A};
    req_valid = 4'b0001;
    wait_grant(g, ok);
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0010;
    wait_resp(ok);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (!ok || {resp_valid, resp_data, resp_id, req_ready} !== {1'b1, 8'h99, 2'd0, 4'b0000}) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b d=%h id=%0d rdy=%b required v=1 d=99 id=0 rdy=0000",
                 c, resp_valid, resp_data, resp_id, req_ready);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({resp_valid, req_ready} !== {1'b0, 4'b0010}) begin
      bad++;
      $display("FAIL bp_regrant got v=%b rdy=%b required v=0 rdy=0010", resp_valid, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, xor_a, xor_b} !== {4'b0000, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL bp_accept got rdy=%b a/b=%b%b required rdy=0000 a/b=11", req_ready, xor_a, xor_b);
    end
    req_valid = '0;
    wait_resp(ok);
    total++;
    if (!ok || resp_data !== 8'h3C || resp_id !== 2'd1) begin
      bad++;
      $display("FAIL bp_resp got ok=%b d=%h id=%0d required d=3c id=1", ok, resp_data, resp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int g;
    bit ok;
    do_reset;
    req_a[23:16] = 8'hFF;
    req_b[23:16] = 8'h00;
    req_valid = 4'b0100;
    wait_grant(g, ok);
    total++;
    if (!ok || g != 2) begin
      bad++;
      $display("FAIL rmid_grant got ok=%b g=%0d required 2", ok, g);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({xor_a, xor_b} !== 2'b10) begin
      bad++;
      $display("FAIL rmid_shift got a/b=%b%b required 10", xor_a, xor_b);
    end
    req_valid = 4'b0101;
    rst_n = 1'b0;
    #1;
    total++;
    if ({resp_valid, resp_data, resp_id, xor_a, xor_b, req_ready} !== '0) begin
      bad++;
      $display("FAIL rmid_zero got v=%b d=%h id=%0d a/b=%b%b rdy=%b required all 0",
               resp_valid, resp_data, resp_id, xor_a, xor_b, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rmid_regrant got rdy=%b required 0001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_resp(ok);
    total++;
    if (!ok || resp_id !== 2'd0) begin
      bad++;
      $display("FAIL rmid_resp got ok=%b id=%0d required 0", ok, resp_id);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_extremes;
    test_round_robin;
    test_ptr_wrap;
    test_backpressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_share_ctrl.md
# xor_share_ctrl

Round-robin scheduler that shares a single 1-bit XOR gate among N requesters. Each requester hands over two WIDTH-bit operands with a valid/ready handshake. The controller streams them LSB-first through the external XOR cell one bit per cycle and returns the WIDTH-bit bitwise XOR with the requester's ID on a valid/ready response port. It sits between requesting logic and the shared gate instance, which is instantiated alongside it.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width in bits (2..32)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  one-hot grant/accept, combinational
- req_a  in  N_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- xor_a  out  1  bit to shared XOR cell input a
- xor_b  out  1  bit to shared XOR cell input b
- xor_y  in  1  shared XOR cell output, combinational from xor_a/xor_b
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  WIDTH  req_a XOR req_b of the granted request
- resp_id  out  clog2(N_REQ)  index of the granted requester

## Operation
- State machine with three states:
  - IDLE: accepts requests.
  - SHIFT: streams bits through the XOR cell.
  - DONE: holds the response.
- Arbitration, in IDLE only:
  - Scan from pointer ptr upward, modulo N_REQ.
  - The first i with req_valid[i]=1 wins, and req_ready[i]=1 (one-hot).
  - All req_ready are 0 in SHIFT and DONE, and 0 when no request is valid.
- Accept happens on an edge where req_valid[i]&req_ready[i]:
  - Latch the operands into shift registers sa and sb.
  - Set id to i, clear bit counter cnt to 0, clear result register r.
  - Go to SHIFT.
- SHIFT behaviour:
  - xor_a=sa[0] and xor_b=sb[0] combinationally.
  - Each edge: r shifts right with xor_y entering r[WIDTH-1]; sa and sb shift right; cnt increments.
  - When cnt reaches WIDTH-1 on an edge, go to DONE.
  - After exactly WIDTH edges, r equals A^B.
- Outside SHIFT, xor_a=xor_b=0.
- DONE behaviour:
  - resp_valid=1, resp_data=r, resp_id=id; all held stable until resp_ready=1.
  - On an edge with resp_ready=1: go to IDLE and set ptr=(id+1) mod N_REQ.
- ptr changes only on response completion. A requester dropping req_valid before being granted is legal. A granted request is fully captured at accept, so later changes to req_a and req_b have no effect.
- cnt width is clog2(WIDTH)+1. There is no overflow path.

## Timing
- Reset (rst_n=0, takes effect asynchronously):
  - state=IDLE, ptr=0, cnt=0, r=0, id=0.
  - resp_valid=0, resp_data=0, resp_id=0, xor_a=xor_b=0.
  - req_ready forced to 0 while rst_n=0.
- Latency: accept at edge E, resp_valid rises after edge E+WIDTH.
- Minimum spacing between accepts is WIDTH+2 edges when resp_ready is held high: WIDTH shift edges, one DONE edge, then IDLE accept.
- resp_ready is sampled only in DONE. resp_ready=1 in other states is ignored.
- req_valid and resp_ready may change at any time. A new request arriving at the same edge a response completes is not accepted that edge; it is arbitrated in the following IDLE cycle with the updated ptr.
- Reset mid-SHIFT or mid-DONE: the transaction is dropped with no response, and the next grant starts from requester 0.
- After rst_n deasserts, the first accept can occur on the first rising edge.

## Test plan
- Single request, N_REQ=4, WIDTH=8, resp_ready=1: req 0, a=0xA5, b=0x3C.
  - Required: resp_data=0x99 and resp_id=0, with resp_valid high exactly 8 edges after accept.
  - Required: xor_a/xor_b sequence LSB-first is 1/0, 0/0, 1/1, 0/1, 0/1, 1/1, 0/0, 1/0.
- Operand extremes:
  - a=0xFF, b=0xFF → 0x00.
  - a=0xFF, b=0x00 → 0xFF.
  - a=0x01, b=0x80 → 0x81.
- Round robin: all four req_valid held high with distinct operands. Required: grant order 0,1,2,3,0, each result correct, never two req_ready bits high at once.
- Pointer wrap: only req 3 valid, completes; then req 0 and req 3 both valid. Required: req 0 is granted next.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE with req 1 pending. Required: resp_valid, resp_data and resp_id stable, req_ready=0 throughout, req 1 accepted one cycle after resp_ready handshake.
- Reset after 3 SHIFT edges with req 2 active. Required: resp_valid=0 and all outputs 0 immediately; after release with req 0 and req 2 valid, req 0 is granted first.
